// File: rtl/clock_meter_pkg.sv
// Shared types and constants for the clock period meter.
package clock_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

  localparam int DEF_CNT_W      = 28;
  localparam int DEF_LOCK_COUNT = 4;

  // All-ones value of a w-bit counter (2^w - 1).
  function automatic logic [63:0] cnt_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/sig_edge_sync.sv
// Synchronizes sig_in into the clk domain and flags its rising edges.
module sig_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic sig_s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      sig_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~sig_d_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period/high time of a slow square wave on sig_in and reports lock/timeout.
// Optional duty-cycle check enabled by `define DUTY_CHECK_EN.
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout,
  output logic             duty_err
);

  localparam int                 MATCH_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(cnt_max(CNT_W));
  localparam logic [MATCH_W-1:0] MATCH_SAT = MATCH_W'(LOCK_COUNT);

  logic sig_s;
  logic rise;

  sig_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_in(sig_in),
    .sig_s (sig_s),
    .rise  (rise)
  );

  meter_state_t       state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   hcnt_q;
  logic [MATCH_W-1:0] match_q;
  logic               first_q;
  logic [CNT_W-1:0]   period_q;
  logic [CNT_W-1:0]   high_q;
  logic               mv_q;
  logic               locked_q;
  logic               timeout_q;

  logic [CNT_W-1:0]   period_d;
  logic [MATCH_W-1:0] match_d;
  logic               hit_d;

  assign period_d = cnt_q + CNT_W'(1);
  assign match_d  = (match_q == MATCH_SAT) ? match_q : match_q + MATCH_W'(1);
  // The first capture after IDLE has no valid predecessor to compare with.
  assign hit_d    = !first_q && (period_d == period_q);

`ifdef DUTY_CHECK_EN
  logic [CNT_W:0] twice_h_d;
  logic [CNT_W:0] per_ext_d;
  logic [CNT_W:0] diff_d;
  logic           duty_d;
  logic           duty_q;

  assign twice_h_d = {hcnt_q, 1'b0};
  assign per_ext_d = {1'b0, period_d};
  assign diff_d    = (twice_h_d >= per_ext_d) ? twice_h_d - per_ext_d : per_ext_d - twice_h_d;
  assign duty_d    = diff_d > (CNT_W + 1)'(1);
  assign duty_err  = duty_q;
`else
  assign duty_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      match_q   <= '0;
      first_q   <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
      mv_q      <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
`ifdef DUTY_CHECK_EN
      duty_q    <= 1'b0;
`endif
    end else begin
      mv_q      <= 1'b0;
      timeout_q <= 1'b0;
      if (clr) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        hcnt_q   <= '0;
        match_q  <= '0;
        first_q  <= 1'b0;
        period_q <= '0;
        high_q   <= '0;
        locked_q <= 1'b0;
`ifdef DUTY_CHECK_EN
        duty_q   <= 1'b0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              state_q <= MEASURE;
              cnt_q   <= '0;
              hcnt_q  <= CNT_W'(1);
              first_q <= 1'b1;
            end
          end
          MEASURE: begin
            if (rise) begin
              period_q <= period_d;
              high_q   <= hcnt_q;
              mv_q     <= 1'b1;
              cnt_q    <= '0;
              hcnt_q   <= CNT_W'(1);
              first_q  <= 1'b0;
              if (hit_d) begin
                match_q  <= match_d;
                locked_q <= (match_d == MATCH_SAT);
              end else begin
                match_q  <= '0;
                locked_q <= 1'b0;
              end
`ifdef DUTY_CHECK_EN
              duty_q   <= duty_d;
`endif
            end else if (cnt_q == CNT_MAX - CNT_W'(1)) begin
              // Counter is about to saturate: give up on this signal.
              cnt_q     <= CNT_MAX;
              state_q   <= IDLE;
              timeout_q <= 1'b1;
              locked_q  <= 1'b0;
              match_q   <= '0;
`ifdef DUTY_CHECK_EN
              duty_q    <= 1'b0;
`endif
            end else begin
              cnt_q  <= cnt_q + CNT_W'(1);
              hcnt_q <= hcnt_q + CNT_W'(sig_s);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = mv_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench for clock_period_meter against a segment-level reference model.
module tb_clock_period_meter;

  localparam int CNT_W = 8;
  localparam int LC    = 4;
  localparam int SS    = 2;
`ifdef DUTY_CHECK_EN
  localparam bit DUTY_EN = 1'b1;
`else
  localparam bit DUTY_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sig_in = 1'b0;
  logic             clr = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             timeout;
  logic             duty_err;

  clock_period_meter #(.CNT_W(CNT_W), .LOCK_COUNT(LC), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .clr       (clr),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .locked    (locked),
    .timeout   (timeout),
    .duty_err  (duty_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p;
    int h;
    bit lk;
    bit du;
    int c;
  } cap_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   to_cnt = 0;
  int   to_cyc = 0;
  cap_t obs[$];
  cap_t exp_q[$];
  int   seg_h[$];
  int   seg_l[$];

  task automatic tick(input logic v);
    sig_in = v;
    @(posedge clk);
    #1;
    cyc++;
    if (meas_valid) obs.push_back('{int'(period), int'(high_time), locked, duty_err, cyc});
    if (timeout) begin
      to_cnt++;
      to_cyc = cyc;
    end
  endtask

  task automatic run_segs();
    for (int k = 0; k < seg_h.size(); k++) begin
      repeat (seg_h[k]) tick(1'b1);
      repeat (seg_l[k]) tick(1'b0);
    end
  endtask

  task automatic clear_meter();
    clr = 1'b1;
    tick(1'b0);
    clr = 1'b0;
    repeat (3) tick(1'b0);
    obs.delete();
    seg_h.delete();
    seg_l.delete();
    to_cnt = 0;
  endtask

  // Reference: each rise ends the previous segment; the first rise only arms the meter.
  task automatic model_segs();
    int prev;
    int run;
    int p;
    int hh;
    int d;
    exp_q.delete();
    prev = 0;
    run  = 0;
    for (int k = 1; k < seg_h.size(); k++) begin
      p  = seg_h[k-1] + seg_l[k-1];
      hh = seg_h[k-1];
      if (k > 1 && p == prev) run = (run < LC) ? run + 1 : LC;
      else run = 0;
      d = 2 * hh - p;
      if (d < 0) d = -d;
      exp_q.push_back('{p, hh, (run == LC), (DUTY_EN && d > 1), 0});
      prev = p;
    end
  endtask

  task automatic add_seg(input int h, input int l);
    seg_h.push_back(h);
    seg_l.push_back(l);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (period !== '0 || high_time !== '0) begin
      errors++;
      $display("FAIL reset_data: period=%0d high_time=%0d, expected 0 0", period, high_time);
    end
    checks++;
    if ({meas_valid, locked, timeout, duty_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: mv/lk/to/du=%b, expected 0000", {meas_valid, locked, timeout, duty_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick(1'b0);
  endtask

  task automatic test_div4();
    clear_meter();
    repeat (10) add_seg(2, 2);
    add_seg(2, 6);
    model_segs();
    run_segs();
    checks++;
    if (obs.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL div4_count: got %0d captures, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].p !== exp_q[i].p || obs[i].h !== exp_q[i].h || obs[i].lk !== exp_q[i].lk || obs[i].du !== exp_q[i].du) begin
        errors++;
        $display("FAIL div4_cap%0d: got p=%0d h=%0d lk=%0d du=%0d, expected p=%0d h=%0d lk=%0d du=%0d",
                 i, obs[i].p, obs[i].h, obs[i].lk, obs[i].du, exp_q[i].p, exp_q[i].h, exp_q[i].lk, exp_q[i].du);
      end
      if (i > 0) begin
        checks++;
        if (obs[i].c - obs[i-1].c !== 4) begin
          errors++;
          $display("FAIL div4_spacing%0d: got %0d cycles, expected 4", i, obs[i].c - obs[i-1].c);
        end
      end
    end
  endtask

  task automatic test_div2();
    clear_meter();
    repeat (10) add_seg(1, 1);
    add_seg(2, 6);
    model_segs();
    run_segs();
    checks++;
    if (obs.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL div2_count: got %0d captures, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].p !== exp_q[i].p || obs[i].h !== exp_q[i].h || obs[i].lk !== exp_q[i].lk || obs[i].du !== exp_q[i].du) begin
        errors++;
        $display("FAIL div2_cap%0d: got p=%0d h=%0d lk=%0d du=%0d, expected p=%0d h=%0d lk=%0d du=%0d",
                 i, obs[i].p, obs[i].h, obs[i].lk, obs[i].du, exp_q[i].p, exp_q[i].h, exp_q[i].lk, exp_q[i].du);
      end
    end
  endtask

  task automatic test_relock();
    clear_meter();
    repeat (7) add_seg(8, 8);
    repeat (7) add_seg(9, 8);
    add_seg(2, 6);
    model_segs();
    run_segs();
    checks++;
    if (obs.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL relock_count: got %0d captures, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].p !== exp_q[i].p || obs[i].h !== exp_q[i].h || obs[i].lk !== exp_q[i].lk || obs[i].du !== exp_q[i].du) begin
        errors++;
        $display("FAIL relock_cap%0d: got p=%0d h=%0d lk=%0d du=%0d, expected p=%0d h=%0d lk=%0d du=%0d",
                 i, obs[i].p, obs[i].h, obs[i].lk, obs[i].du, exp_q[i].p, exp_q[i].h, exp_q[i].lk, exp_q[i].du);
      end
    end
  endtask

  task automatic test_timeout();
    clear_meter();
    repeat (7) add_seg(8, 8);
    add_seg(1, 300);
    model_segs();
    run_segs();
    checks++;
    if (obs.size() !== exp_q.size() || obs.size() == 0) begin
      errors++;
      $display("FAIL timeout_caps: got %0d captures, expected %0d", obs.size(), exp_q.size());
    end else begin
      checks++;
      if (obs[obs.size()-1].lk !== 1'b1) begin
        errors++;
        $display("FAIL timeout_prelock: locked=%0d before timeout, expected 1", obs[obs.size()-1].lk);
      end
      checks++;
      if (to_cyc - obs[obs.size()-1].c !== 255) begin
        errors++;
        $display("FAIL timeout_delay: got %0d cycles after last rise, expected 255", to_cyc - obs[obs.size()-1].c);
      end
    end
    checks++;
    if (to_cnt !== 1) begin
      errors++;
      $display("FAIL timeout_pulses: got %0d pulses, expected 1", to_cnt);
    end
    checks++;
    if (locked !== 1'b0 || period !== 8'd16 || high_time !== 8'd8) begin
      errors++;
      $display("FAIL timeout_hold: locked=%0d period=%0d high=%0d, expected 0 16 8", locked, period, high_time);
    end
  endtask

  task automatic test_clr_on_rise();
    int n0;
    clear_meter();
    repeat (6) add_seg(4, 4);
    add_seg(4, 4);
    model_segs();
    run_segs();
    checks++;
    if (obs.size() !== exp_q.size() || obs.size() == 0 || obs[obs.size()-1].lk !== exp_q[exp_q.size()-1].lk) begin
      errors++;
      $display("FAIL clr_prelock: got %0d captures, expected %0d with final lock", obs.size(), exp_q.size());
    end
    n0 = obs.size();
    tick(1'b1);
    tick(1'b1);
    clr = 1'b1;
    tick(1'b1);
    clr = 1'b0;
    checks++;
    if (obs.size() !== n0) begin
      errors++;
      $display("FAIL clr_no_valid: got %0d captures, expected %0d", obs.size(), n0);
    end
    checks++;
    if (period !== '0 || high_time !== '0 || {meas_valid, locked, timeout, duty_err} !== 4'b0) begin
      errors++;
      $display("FAIL clr_zero: period=%0d high=%0d flags=%b, expected 0 0 0000",
               period, high_time, {meas_valid, locked, timeout, duty_err});
    end
    tick(1'b1);
    tick(1'b1);
    repeat (4) tick(1'b0);
    obs.delete();
    seg_h.delete();
    seg_l.delete();
    add_seg(4, 4);
    add_seg(4, 4);
    add_seg(2, 6);
    model_segs();
    run_segs();
    checks++;
    if (obs.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL clr_after_count: got %0d captures, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].p !== exp_q[i].p || obs[i].h !== exp_q[i].h || obs[i].lk !== exp_q[i].lk) begin
        errors++;
        $display("FAIL clr_after_cap%0d: got p=%0d h=%0d lk=%0d, expected p=%0d h=%0d lk=%0d",
                 i, obs[i].p, obs[i].h, obs[i].lk, exp_q[i].p, exp_q[i].h, exp_q[i].lk);
      end
    end
  endtask

  task automatic test_async_reset();
    clear_meter();
    repeat (3) add_seg(5, 5);
    run_segs();
    tick(1'b1);
    tick(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (period !== '0 || high_time !== '0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL areset_zero: period=%0d high=%0d locked=%0d, expected 0 0 0", period, high_time, locked);
    end
    sig_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick(1'b0);
    obs.delete();
    seg_h.delete();
    seg_l.delete();
    add_seg(5, 5);
    add_seg(3, 5);
    add_seg(2, 6);
    model_segs();
    run_segs();
    checks++;
    if (obs.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL areset_count: got %0d captures, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].p !== exp_q[i].p || obs[i].h !== exp_q[i].h || obs[i].lk !== exp_q[i].lk) begin
        errors++;
        $display("FAIL areset_cap%0d: got p=%0d h=%0d lk=%0d, expected p=%0d h=%0d lk=%0d",
                 i, obs[i].p, obs[i].h, obs[i].lk, exp_q[i].p, exp_q[i].h, exp_q[i].lk);
      end
    end
  endtask

  task automatic test_duty();
    clear_meter();
    add_seg(6, 2);
    add_seg(6, 2);
    add_seg(4, 4);
    add_seg(4, 4);
    add_seg(2, 6);
    model_segs();
    run_segs();
    checks++;
    if (obs.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL duty_count: got %0d captures, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].p !== exp_q[i].p || obs[i].h !== exp_q[i].h || obs[i].du !== exp_q[i].du) begin
        errors++;
        $display("FAIL duty_cap%0d: got p=%0d h=%0d du=%0d, expected p=%0d h=%0d du=%0d",
                 i, obs[i].p, obs[i].h, obs[i].du, exp_q[i].p, exp_q[i].h, exp_q[i].du);
      end
    end
  endtask

  task automatic test_random();
    int h;
    int l;
    clear_meter();
    h = 3;
    l = 3;
    for (int k = 0; k < 40; k++) begin
      if (k == 0 || $urandom_range(1, 0) == 0) begin
        h = $urandom_range(5, 1);
        l = $urandom_range(5, 1);
      end
      add_seg(h, l);
    end
    add_seg(2, 6);
    model_segs();
    run_segs();
    checks++;
    if (obs.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d captures, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].p !== exp_q[i].p || obs[i].h !== exp_q[i].h || obs[i].lk !== exp_q[i].lk || obs[i].du !== exp_q[i].du) begin
        errors++;
        $display("FAIL rand_cap%0d: got p=%0d h=%0d lk=%0d du=%0d, expected p=%0d h=%0d lk=%0d du=%0d",
                 i, obs[i].p, obs[i].h, obs[i].lk, obs[i].du, exp_q[i].p, exp_q[i].h, exp_q[i].lk, exp_q[i].du);
      end
    end
  endtask

  initial begin
    test_reset();
    test_div4();
    test_div2();
    test_relock();
    test_timeout();
    test_clr_on_rise();
    test_async_reset();
    test_duty();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
